// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - UART receive front end: baud tick divider, rx synchronizer, majority filter, mid-bit sampler
module uart_rx_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx_sample_cnt_reset,
    output logic                 rx_clk_en,
    output logic                 rx_sync_out,
    output logic                 rx_sync_fall,
    output logic                 rx_get_sample,
    output logic                 rx_noise
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic                   tick_q, tick_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;
    logic [2:0]             hist_q, hist_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;

    // >= rather than == so a baud_div drop below div_cnt wraps immediately
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        tick_d    = 1'b0;
        if (div_cnt_q >= baud_div) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end
    end

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        hist_d       = hist_q;
        filt_d       = filt_q;
        filt_prev_d  = filt_prev_q;
        sample_cnt_d = sample_cnt_q;
        if (tick_q) begin
            hist_d      = {hist_q[1:0], sync_bit};
            filt_d      = (hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) | (hist_d[1] & hist_d[2]);
            filt_prev_d = filt_q;
            if (rx_sample_cnt_reset || (sample_cnt_q == CNT_LAST)) begin
                sample_cnt_d = '0;
            end else begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q    <= '0;
            tick_q       <= 1'b0;
            sync_q       <= '1;
            hist_q       <= 3'b111;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            sample_cnt_q <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            tick_q       <= tick_d;
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_prev_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Every strobe is gated by tick_q so it lasts exactly one clk
    assign rx_clk_en     = tick_q;
    assign rx_sync_out   = filt_q;
    assign rx_sync_fall  = tick_q & filt_prev_q & ~filt_q;
    assign rx_get_sample = tick_q & (sample_cnt_q == CNT_MID);
    assign rx_noise      = rx_get_sample & ~(&hist_q) & (|hist_q);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - self-checking bench for uart_rx_frontend
module tb_uart_rx_frontend;

    localparam int SYNC_STAGES = 2;
    localparam int OVERSAMPLE  = 16;
    localparam int DIV_WIDTH   = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rx = 1'b1;
    logic [DIV_WIDTH-1:0] baud_div = 16'd3;
    logic                 rx_sample_cnt_reset = 1'b0;
    logic                 rx_clk_en, rx_sync_out, rx_sync_fall, rx_get_sample, rx_noise;

    int checks = 0;
    int errors = 0;

    uart_rx_frontend #(
        .SYNC_STAGES(SYNC_STAGES),
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx                 (rx),
        .baud_div           (baud_div),
        .rx_sample_cnt_reset(rx_sample_cnt_reset),
        .rx_clk_en          (rx_clk_en),
        .rx_sync_out        (rx_sync_out),
        .rx_sync_fall       (rx_sync_fall),
        .rx_get_sample      (rx_get_sample),
        .rx_noise           (rx_noise)
    );

    always #5 clk = ~clk;

    wire [4:0] dut_vec = {rx_clk_en, rx_sync_out, rx_sync_fall, rx_get_sample, rx_noise};

    // Reference model: delay line of raw rx, list of the last three tick samples,
    // integer tick timer and bit-position counter.
    int m_div;
    bit m_tick;
    bit m_line[$];
    bit m_samples[$];
    bit m_filt, m_filt_prev;
    int m_pos;

    function automatic int sample_ones();
        return int'(m_samples[0]) + int'(m_samples[1]) + int'(m_samples[2]);
    endfunction

    function automatic logic [4:0] model_vec();
        bit get;
        bit fall;
        bit noise;
        get   = m_tick && (m_pos == OVERSAMPLE / 2 - 1);
        fall  = m_tick && m_filt_prev && !m_filt;
        noise = get && (sample_ones() != 0) && (sample_ones() != 3);
        return {m_tick, m_filt, fall, get, noise};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_div = 0;
            m_tick = 1'b0;
            m_line = {};
            for (int i = 0; i < SYNC_STAGES; i++) m_line.push_back(1'b1);
            m_samples = {};
            for (int i = 0; i < 3; i++) m_samples.push_back(1'b1);
            m_filt = 1'b1;
            m_filt_prev = 1'b1;
            m_pos = 0;
        end else begin
            if (m_tick) begin
                m_samples.push_back(m_line[0]);
                void'(m_samples.pop_front());
                m_filt_prev = m_filt;
                m_filt = (sample_ones() >= 2);
                m_pos = rx_sample_cnt_reset ? 0 : (m_pos + 1) % OVERSAMPLE;
            end
            m_line.push_back(rx);
            void'(m_line.pop_front());
            if (m_div >= int'(baud_div)) begin
                m_div = 0;
                m_tick = 1'b1;
            end else begin
                m_div = m_div + 1;
                m_tick = 1'b0;
            end
        end
    end

    task automatic test_reset();
        int k;
        #2;
        checks++;
        if (dut_vec !== 5'b01000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 01000", dut_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (dut_vec !== 5'b01000) begin
            errors++;
            $display("FAIL reset_hold_over_edge: got %b expected 01000", dut_vec);
        end
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!rx_clk_en && k < 20);
        checks++;
        if (k !== 4) begin
            errors++;
            $display("FAIL first_tick_after_reset: got %0d clks expected 4", k);
        end
    endtask

    task automatic test_divider();
        int highs = 0;
        int k = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (rx_clk_en) highs++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL div3_model cycle %0d: got %b expected %b", n, dut_vec, model_vec());
            end
        end
        checks++;
        if (highs !== 4) begin
            errors++;
            $display("FAIL div3_tick_count: got %0d expected 4", highs);
        end
        @(negedge clk);
        while (m_div != 2 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 10) begin
            errors++;
            $display("FAIL div_cnt2_wait: got timeout expected div_cnt 2");
        end
        baud_div = 16'd0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++;
            if (rx_clk_en !== 1'b1 || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL div0_every_clk cycle %0d: got %b expected clk_en 1 vec %b", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_start_edge();
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n <= 45; n++) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL start_model T%0d: got %b expected %b", n, dut_vec, model_vec());
            end
            checks++;
            if (rx_sync_fall !== (n == 2) || rx_sync_out !== (n < 2)) begin
                errors++;
                $display("FAIL start_fall T%0d: got fall %b out %b expected fall %b out %b",
                         n, rx_sync_fall, rx_sync_out, (n == 2), (n < 2));
            end
            if (n >= 3) begin
                checks++;
                if (rx_get_sample !== (n == 10 || n == 26 || n == 42)) begin
                    errors++;
                    $display("FAIL start_get_sample T%0d: got %b expected %b",
                             n, rx_get_sample, (n == 10 || n == 26 || n == 42));
                end
            end
            if (n == 10) begin
                checks++;
                if (dut_vec !== 5'b10010) begin
                    errors++;
                    $display("FAIL start_mid_bit T10: got %b expected 10010", dut_vec);
                end
            end
            rx_sample_cnt_reset = (n == 2);
            @(negedge clk);
        end
        rx_sample_cnt_reset = 1'b0;
        rx = 1'b1;
    endtask

    task automatic test_glitch();
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if (rx_sync_out !== 1'b1 || rx_sync_fall !== 1'b0 || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL glitch cycle %0d: got %b expected out 1 fall 0 vec %b", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_noise();
        rx = 1'b1;
        repeat (8) @(negedge clk);
        for (int n = 0; n <= 26; n++) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL noise_model cycle %0d: got %b expected %b", n, dut_vec, model_vec());
            end
            if (n == 8) begin
                checks++;
                if (dut_vec !== 5'b11011) begin
                    errors++;
                    $display("FAIL noise_101: got %b expected 11011", dut_vec);
                end
            end
            if (n == 24) begin
                checks++;
                if (dut_vec !== 5'b10010) begin
                    errors++;
                    $display("FAIL noise_000: got %b expected 10010", dut_vec);
                end
            end
            rx_sample_cnt_reset = (n == 0);
            rx = (n == 4 || n >= 9) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rx_sample_cnt_reset = 1'b0;
        rx = 1'b1;
    endtask

    task automatic test_qualification();
        logic [3:0] prev = 4'b0;
        logic [3:0] cur;
        int ticks = 0;
        int last_get = -1;
        int gets = 0;
        baud_div = 16'd5;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            cur = {rx_clk_en, rx_sync_fall, rx_get_sample, rx_noise};
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL qual_model cycle %0d: got %b expected %b", n, dut_vec, model_vec());
            end
            checks++;
            if ((prev & cur) !== 4'b0) begin
                errors++;
                $display("FAIL qual_strobe_width cycle %0d: got %b after %b expected no overlap", n, cur, prev);
            end
            if (m_tick) ticks++;
            if (rx_get_sample) begin
                if (last_get >= 0) begin
                    checks++;
                    if (ticks - last_get !== OVERSAMPLE) begin
                        errors++;
                        $display("FAIL qual_get_period: got %0d ticks expected %0d", ticks - last_get, OVERSAMPLE);
                    end
                end
                last_get = ticks;
                gets++;
            end
            prev = cur;
            rx_sample_cnt_reset = !m_tick;
            if ($urandom_range(0, 39) == 0) rx = ~rx;
        end
        checks++;
        if (gets < 3) begin
            errors++;
            $display("FAIL qual_get_seen: got %0d strobes expected at least 3", gets);
        end
        rx_sample_cnt_reset = 1'b0;
        rx = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_model cycle %0d div %0d: got %b expected %b", n, baud_div, dut_vec, model_vec());
            end
            if (n % 200 == 0) baud_div = DIV_WIDTH'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) rx = ~rx;
            rx_sample_cnt_reset = ($urandom_range(0, 19) == 0);
        end
        rx_sample_cnt_reset = 1'b0;
    endtask

    task automatic test_async_reset();
        int k;
        logic stray = 1'b0;
        baud_div = 16'd3;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (rx_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL async_precondition: got sync_out %b expected 0", rx_sync_out);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        rx = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 5'b01000) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected 01000", dut_vec);
        end
        #2;
        reset = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (!rx_clk_en && (rx_sync_fall || rx_get_sample || rx_noise)) stray = 1'b1;
        end while (!rx_clk_en && k < 20);
        checks++;
        if (k !== 4 || stray) begin
            errors++;
            $display("FAIL async_first_tick: got %0d clks stray %b expected 4 clks stray 0", k, stray);
        end
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL async_after_model cycle %0d: got %b expected %b", n, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        test_reset();
        test_divider();
        test_start_edge();
        test_glitch();
        test_noise();
        test_qualification();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SYNC_STAGES, 2, metastability flops on rx; legal values >=2.
  OVERSAMPLE, 16, oversample ticks per bit; even, >=4.
  DIV_WIDTH, 16, width of baud_div.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk, in, 1, system clock.
  reset, in, 1, asynchronous active-low reset.
  rx, in, 1, asynchronous serial line; idle high.
  baud_div, in, DIV_WIDTH, clk cycles per oversample tick minus 1.
  rx_sample_cnt_reset, in, 1, restart bit timing; from the RX controller.
  rx_clk_en, out, 1, oversample tick strobe.
  rx_sync_out, out, 1, filtered line level.
  rx_sync_fall, out, 1, filtered falling edge; tick-qualified.
  rx_get_sample, out, 1, mid-bit sample strobe; tick-qualified.
  rx_noise, out, 1, sample window not unanimous; tick-qualified.

Function
REQ-004 Tick divider: div_cnt SHALL increment every clk.
  - When div_cnt >= baud_div: div_cnt <= 0 and the tick register <= 1.
  - Otherwise the tick register <= 0.
  - rx_clk_en SHALL be the tick register output.
  - Period is baud_div+1 clks; baud_div=0 gives rx_clk_en high every cycle.
REQ-005 A baud_div decrease below the current div_cnt SHALL wrap on the next clk, with no counter overrun.
REQ-006 rx SHALL pass through SYNC_STAGES flops clocked every clk; the last stage output is sync_bit.
REQ-007 On each tick, the 3-bit history SHALL shift in sync_bit: history <= {history[1:0], sync_bit}.
REQ-008 On each tick, both filter registers SHALL update:
  - filt <= majority of the new history.
  - filt_prev <= old filt.
  - rx_sync_out = filt.
REQ-009 rx_sync_fall SHALL equal rx_clk_en AND filt_prev AND NOT filt.
  - It asserts on exactly one tick: the tick after filt falls.
REQ-010 sample_cnt has width clog2(OVERSAMPLE).
  - Updates only on a tick.
  - If rx_sample_cnt_reset=1: sample_cnt <= 0.
  - Else if sample_cnt = OVERSAMPLE-1: sample_cnt <= 0.
  - Else sample_cnt <= sample_cnt+1.
REQ-011 rx_sample_cnt_reset SHALL be ignored in non-tick cycles.
REQ-012 rx_get_sample SHALL equal rx_clk_en AND (sample_cnt = OVERSAMPLE/2-1), compared against the pre-update value.
  - It first asserts OVERSAMPLE/2 ticks after the reset tick.
  - It then repeats every OVERSAMPLE ticks.
REQ-013 rx_noise SHALL equal rx_get_sample AND (history not all-0 and not all-1).
REQ-014 All tick-qualified outputs SHALL be 0 in every non-tick cycle, so downstream combinational enables pulse for exactly one clk.
REQ-015 Latency:
  - An rx edge reaches sync_bit after SYNC_STAGES clk edges.
  - filt changes on the 2nd tick that samples the new level.
  - rx_sync_fall follows on the next tick.
REQ-016 A single-tick opposite-level sample SHALL NOT change filt.
REQ-017 sample_cnt SHALL free-run while idle; the controller realigns it through rx_sample_cnt_reset.

Reset
REQ-018 While reset=0, all of the following SHALL hold immediately, independent of clk:
  - Synchronizer flops = 1, history = 3'b111, filt = 1, filt_prev = 1.
  - div_cnt = 0, sample_cnt = 0, tick register = 0.
  - rx_clk_en = 0, rx_sync_out = 1, rx_sync_fall = 0, rx_get_sample = 0, rx_noise = 0.
REQ-019 After reset deasserts, the first rx_clk_en SHALL occur baud_div+1 clks later.
REQ-020 Reset asserted mid-frame SHALL abort all timing, with no residual strobes after release.

Verification
REQ-021 Divider: baud_div=3 -> rx_clk_en high 1 clk in every 4; change to 0 while div_cnt=2 -> wrap next clk, then high every clk.
REQ-022 Start edge: OVERSAMPLE=16, baud_div=0, rx high->low at tick T0 (post-sync) -> filt=0 at T1; rx_sync_fall=1 only at T2.
  - rx_sample_cnt_reset=1 at T2 -> rx_get_sample at T10, T26, T42 with rx_sync_out=0 at T10.
REQ-023 Glitch: rx low for exactly one tick window -> rx_sync_out stays 1; rx_sync_fall never asserts.
REQ-024 Noise: history 3'b101 at a mid-bit tick -> rx_get_sample=1, rx_noise=1, rx_sync_out=1; history 3'b000 -> rx_noise=0.
REQ-025 Qualification: baud_div=5, rx_sample_cnt_reset held high in non-tick cycles only -> sample_cnt unaffected; no strobe ever lasts more than 1 clk.
REQ-026 Async reset: reset=0 pulsed between clk edges mid-frame -> outputs at REQ-018 values before the next edge; first tick at baud_div+1 clks after release.
